mips_mul_div_unit: RTL and testbench

// - Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// - Sits in the EX stage beside the ALU; operands arrive from the EX operand-select muxes.
// - The EX stage stalls while a new MDU-using instruction sees busy=1.
// - EX gates start with its own stall, so start is only asserted for an instruction that actually issues.

---
 rtl/mips_mul_div_unit.sv | 86 ++++++++
 tb/tb_mips_mul_div_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mips_mul_div_unit.sv
// mips_mul_div_unit: multi-cycle MIPS multiply/divide unit owning the HI/LO registers
module mips_mul_div_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] operand1,
   input  logic [31:0] operand2,
   input  logic [3:0]  operation,
   input  logic        start,
   output logic        busy,
   output logic [31:0] dataRead
);
   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [3:0] OP_MFHI = 4'd1, OP_MFLO = 4'd2, OP_MTHI = 4'd3, OP_MTLO = 4'd4,
                          OP_MULT = 4'd5, OP_MULTU = 4'd6, OP_DIV = 4'd7, OP_DIVU = 4'd8;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_next;
   logic [CW-1:0] count;
   logic [31:0] hi, lo, op_a, op_b;
   logic [3:0] op_q;
   logic issue, is_md, done, commit;
   logic signed [63:0] prod_s;
   logic [63:0] prod_u, res;
   logic [31:0] div_u, div_s, q_u, r_u;
   logic signed [31:0] q_s, r_s;
   assign busy = (state == RUN);
   assign issue = start && (state == IDLE);
   assign is_md = (operation >= OP_MULT) && (operation <= OP_DIVU);
   assign done = (state == RUN) && (count == CW'(1));
   // divide by zero leaves HI/LO untouched
   assign commit = !((op_q == OP_DIV || op_q == OP_DIVU) && op_b == 32'd0);
   assign prod_s = $signed(op_a) * $signed(op_b);
   assign prod_u = {32'd0, op_a} * {32'd0, op_b};
   // zero divisor is replaced to keep the dividers defined; the overflow case
   // divides by 1 instead, which yields exactly LO=80000000, HI=0
   assign div_u = (op_b == 32'd0) ? 32'd1 : op_b;
   assign div_s = (op_b == 32'd0 || (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF)) ? 32'd1 : op_b;
   assign q_s = $signed(op_a) / $signed(div_s);
   assign r_s = $signed(op_a) % $signed(div_s);
   assign q_u = op_a / div_u;
   assign r_u = op_a % div_u;
   assign res = (op_q == OP_MULT)  ? prod_s :
                (op_q == OP_MULTU) ? prod_u :
                (op_q == OP_DIV)   ? {r_s, q_s} : {r_u, q_u};
   assign dataRead = (operation == OP_MFHI) ? hi : (operation == OP_MFLO) ? lo : 32'd0;
   // busy state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end
   // enter RUN on an accepted mult/div, leave on the completing edge
   always_comb begin
      state_next = state;
      if (issue && is_md) state_next = RUN;
      else if (done)      state_next = IDLE;
   end
   // operand latch, cycle counter and HI/LO updates
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         op_a  <= '0;
         op_b  <= '0;
         op_q  <= '0;
      end else if (issue) begin
         if (operation == OP_MTHI) hi <= operand1;
         if (operation == OP_MTLO) lo <= operand1;
         if (is_md) begin
            op_a  <= operand1;
            op_b  <= operand2;
            op_q  <= operation;
            count <= (operation <= OP_MULTU) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
         end
      end else if (state == RUN) begin
         count <= count - CW'(1);
         if (done && commit) begin
            hi <= res[63:32];
            lo <= res[31:0];
         end
      end
   end
endmodule

// File: tb/tb_mips_mul_div_unit.sv
// tb_mips_mul_div_unit: directed and random checks of the MDU against an arithmetic model
module tb_mips_mul_div_unit;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] operand1 = '0, operand2 = '0;
   logic [3:0]  operation = '0;
   logic        start = 1'b0;
   logic        busy;
   logic [31:0] dataRead;
   int n_checks = 0, n_fail = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   mips_mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clock(clock), .reset(reset), .operand1(operand1), .operand2(operand2),
      .operation(operation), .start(start), .busy(busy), .dataRead(dataRead)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_check(input string tag);
      operation = 4'd1; #1 chk({tag, "_hi"}, dataRead, m_hi);
      operation = 4'd2; #1 chk({tag, "_lo"}, dataRead, m_lo);
      operation = 4'd0; #1 chk({tag, "_none"}, dataRead, 32'd0);
   endtask

   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p, q, r;
      logic [63:0] pu;
      case (op)
         4'd3: m_hi = a;
         4'd4: m_lo = a;
         4'd5: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
         4'd6: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; end
         4'd7: if (b != 0) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[31:0];
            m_hi = r[31:0];
         end
         4'd8: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         default: ;
      endcase
   endtask

   // called at a negedge; returns at the negedge after completion
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      int n;
      operation = op; operand1 = a; operand2 = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0; operation = 4'd0;
      model(op, a, b);
      if (op >= 4'd5 && op <= 4'd8) begin
         n = 0;
         while (busy === 1'b1 && n < 200) begin n++; @(negedge clock); end
         chk({tag, "_busy_cycles"}, n, (op <= 4'd6) ? 32'd5 : 32'd10);
      end else
         chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      rd_check(tag);
   endtask

   initial begin
      int n;
      logic [3:0] op;
      logic [31:0] a, b;
      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rd_check("reset");
      @(negedge clock); reset = 1'b1; @(negedge clock);
      do_op(4'd5, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
      chk("mult_hi_const", m_hi, 32'hFFFF_FFFF);
      do_op(4'd6, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
      chk("multu_hi_const", m_hi, 32'h0000_0002);
      do_op(4'd7, 32'hFFFF_FFF9, 32'd2, "div");
      chk("div_lo_const", m_lo, 32'hFFFF_FFFD);
      do_op(4'd8, 32'd7, 32'd2, "divu");
      do_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      chk("div_ovf_lo_const", m_lo, 32'h8000_0000);
      do_op(4'd3, 32'h0000_1234, 32'd0, "mthi");
      do_op(4'd7, 32'd55, 32'd0, "div_zero");
      chk("div_zero_hi_const", m_hi, 32'h0000_1234);
      do_op(4'd8, 32'd55, 32'd0, "divu_zero");
      do_op(4'd0, 32'hDEAD_BEEF, 32'd1, "none");
      do_op(4'd12, 32'hDEAD_BEEF, 32'd1, "op12");
      // MTLO during busy is ignored and operands are not re-latched
      operation = 4'd8; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
      @(negedge clock);
      model(4'd8, 32'd100, 32'd7);
      operation = 4'd4; operand1 = 32'h0000_CAFE; operand2 = 32'd0;
      @(negedge clock);
      start = 1'b0; operation = 4'd0;
      n = 2;
      while (busy === 1'b1 && n < 200) begin n++; @(negedge clock); end
      chk("ignore_busy_cycles", n, 32'd11);
      rd_check("ignore");
      chk("ignore_lo_const", m_lo, 32'd14);
      do_op(4'd4, 32'h0000_CAFE, 32'd0, "mtlo_retry");
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
         do_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      end
      // async reset in the middle of a MULT aborts it
      do_op(4'd3, 32'h5555_AAAA, 32'd0, "pre_reset");
      operation = 4'd5; operand1 = 32'd1234; operand2 = 32'd5678; start = 1'b1;
      @(negedge clock);
      start = 1'b0; operation = 4'd0;
      @(negedge clock);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1 chk("abort_busy", {31'd0, busy}, 32'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clock); reset = 1'b1;
      repeat (6) @(negedge clock);
      chk("after_reset_busy", {31'd0, busy}, 32'd0);
      rd_check("after_reset");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
